// File: rtl/handshake_fanout_fifo.sv
// Elastic buffer: an upstream req/ack initiator feeding output_size
// independent downstream responders. Every word reaches every consumer
// once, in order; an entry retires after all consumers have taken it.
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   req_l      request to upstream responder (one outstanding at most)
//   ack_l      upstream one-cycle ack; din valid in the same cycle
//   din        upstream data word
//   req_r[k]   request from consumer k
//   ack_r[k]   one-cycle ack pulse to consumer k
//   dout       data for consumer k on slice [dw*(k+1)-1:dw*k]
//   count      entries not yet taken by every consumer
//   stall_cnt  only with HANDSHAKE_FANOUT_FIFO_STALL_CNT_EN: saturating
//              count of cycles a drained consumer waits on a full FIFO
module handshake_fanout_fifo #(
   parameter int data_width  = 32,
   parameter int depth       = 4,
   parameter int addr_width  = 2,
   parameter int output_size = 2
) (
   input  logic                              clk,
   input  logic                              rst,
   output logic                              req_l,
   input  logic                              ack_l,
   input  logic [data_width-1:0]             din,
   input  logic [output_size-1:0]            req_r,
   output logic [output_size-1:0]            ack_r,
   output logic [data_width*output_size-1:0] dout,
   output logic [addr_width:0]               count
`ifdef HANDSHAKE_FANOUT_FIFO_STALL_CNT_EN
   ,
   output logic [31:0]                       stall_cnt
`endif
);

   typedef enum logic {IDLE, WAIT} state_t;

   localparam logic [addr_width:0] DEPTH_C = (addr_width+1)'(depth);
   localparam logic [addr_width:0] ONE_C   = (addr_width+1)'(1);

   state_t                           state_q;
   logic                             req_l_q;
   logic [data_width-1:0]            mem_q [depth];
   logic [addr_width:0]              wr_ptr_q;
   logic [addr_width:0]              tail_q;
   logic [addr_width:0]              rd_ptr_q [output_size];
   logic [output_size-1:0]           ack_r_q;
   logic [data_width*output_size-1:0] dout_q;

   logic                             wr_en;
   logic                             retire;
   logic [output_size-1:0]           take;

   // Pointers carry one extra wrap bit, so full and empty differ.
   assign count = wr_ptr_q - tail_q;
   assign wr_en = (state_q == WAIT) && ack_l;

   assign req_l = req_l_q;
   assign ack_r = ack_r_q;
   assign dout  = dout_q;

   // Emptiness uses the registered wr_ptr: no write-to-read bypass.
   // Tail advances only once every consumer has moved past it.
   always_comb begin
      retire = (tail_q != wr_ptr_q);
      take   = '0;
      for (int k = 0; k < output_size; k++) begin
         take[k] = req_r[k] & ~ack_r_q[k]
                 & (rd_ptr_q[k] != wr_ptr_q);
         if (rd_ptr_q[k] == tail_q)
            retire = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         req_l_q  <= 1'b0;
         wr_ptr_q <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (count < DEPTH_C) begin
                  req_l_q <= 1'b1;
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               if (ack_l) begin
                  req_l_q  <= 1'b0;
                  wr_ptr_q <= wr_ptr_q + ONE_C;
                  state_q  <= IDLE;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && wr_en)
         mem_q[wr_ptr_q[addr_width-1:0]] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ack_r_q <= '0;
         dout_q  <= '0;
         tail_q  <= '0;
         for (int k = 0; k < output_size; k++)
            rd_ptr_q[k] <= '0;
      end else begin
         ack_r_q <= take;
         for (int k = 0; k < output_size; k++) begin
            if (take[k]) begin
               dout_q[k*data_width +: data_width] <=
                  mem_q[rd_ptr_q[k][addr_width-1:0]];
               rd_ptr_q[k] <= rd_ptr_q[k] + ONE_C;
            end
         end
         if (retire)
            tail_q <= tail_q + ONE_C;
      end
   end

`ifdef HANDSHAKE_FANOUT_FIFO_STALL_CNT_EN
   logic [31:0] stall_cnt_q;
   logic        blocked;

   // A requesting consumer that has already drained the FIFO.
   always_comb begin
      blocked = 1'b0;
      for (int k = 0; k < output_size; k++)
         if (req_r[k] && (rd_ptr_q[k] == wr_ptr_q))
            blocked = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst)
         stall_cnt_q <= '0;
      else if ((count == DEPTH_C) && blocked
               && (stall_cnt_q != '1))
         stall_cnt_q <= stall_cnt_q + 32'd1;
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule
